// File: rtl/ctrl_pkg.sv
// Shared types for the control-signal pipeline: per-stage control bundles
// and their bubble (all-zero) values.
package ctrl_pkg;

    typedef struct packed {
        logic       valid;
        logic [3:0] cond;
        logic [1:0] flagw;
        logic       pcs;
        logic       regw;
        logic       memw;
        logic       branch;
        logic       memtoreg;
        logic       alusrc;
        logic       bedmem;
        logic       bl;
        logic [3:0] alucontrol;
        logic [3:0] wa3;
    } ctrl_e_t;

    typedef struct packed {
        logic       valid;
        logic       regwrite;
        logic       memwrite;
        logic       memtoreg;
        logic       bedmem;
        logic       bl;
        logic       pcsrc;
        logic [3:0] wa3;
    } ctrl_m_t;

    typedef struct packed {
        logic       valid;
        logic       regwrite;
        logic       memtoreg;
        logic       bl;
        logic       pcsrc;
        logic [3:0] wa3;
    } ctrl_w_t;

    localparam ctrl_e_t CTRL_E_BUBBLE = '0;
    localparam ctrl_m_t CTRL_M_BUBBLE = '0;
    localparam ctrl_w_t CTRL_W_BUBBLE = '0;

endpackage

// File: rtl/ctrl_pipe_reg.sv
// Generic pipeline register: async reset and synchronous clear both load
// RST_VAL; clear takes priority over enable.
module pipe_reg #(
    parameter int unsigned    W       = 8,
    parameter logic [W-1:0]   RST_VAL = '0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic         clr,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q <= RST_VAL;
        end else if (clr) begin
            q <= RST_VAL;
        end else if (en) begin
            q <= d;
        end
    end

endmodule

// File: rtl/ctrl_pipe.sv
// Control-signal pipeline Decode->Execute->Memory->Writeback with hazard
// bubble insertion and a retired-instruction counter.
module ctrl_pipe
    import ctrl_pkg::*;
#(
    parameter int unsigned CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             StallE,
    input  logic             FlushE,
    input  logic             ValidD,
    input  logic [3:0]       CondD,
    input  logic [1:0]       FlagWD,
    input  logic             PCSD,
    input  logic             RegWD,
    input  logic             MemWD,
    input  logic             BranchD,
    input  logic             MemtoRegD,
    input  logic             ALUSrcD,
    input  logic             BEDmemD,
    input  logic             BLD,
    input  logic [3:0]       ALUControlD,
    input  logic [3:0]       WA3D,
    input  logic             PCSrcE,
    input  logic             RegWriteE,
    input  logic             MemWriteE,
    output logic [3:0]       CondE,
    output logic [1:0]       FlagWE,
    output logic [3:0]       ALUControlE,
    output logic             PCSE,
    output logic             RegWE,
    output logic             MemWE,
    output logic             BranchE,
    output logic             MemtoRegE,
    output logic             ALUSrcE,
    output logic             BEDmemE,
    output logic             BLE,
    output logic             ValidE,
    output logic [3:0]       WA3E,
    output logic             RegWriteM,
    output logic             MemWriteM,
    output logic             MemtoRegM,
    output logic             BEDmemM,
    output logic             BLM,
    output logic             PCSrcM,
    output logic             ValidM,
    output logic [3:0]       WA3M,
    output logic             RegWriteW,
    output logic             MemtoRegW,
    output logic             BLW,
    output logic             PCSrcW,
    output logic             ValidW,
    output logic [3:0]       WA3W,
    output logic [CNT_W-1:0] RetireCount
);

    ctrl_e_t e_d, e_q;
    ctrl_m_t m_d, m_q;
    ctrl_w_t w_d, w_q;
    logic    e_hold;
    logic [CNT_W-1:0] cnt;

    // E held without a flush means nothing leaves E this cycle
    assign e_hold = StallE & ~FlushE;

    always_comb begin
        e_d            = CTRL_E_BUBBLE;
        e_d.valid      = ValidD;
        e_d.cond       = CondD;
        e_d.flagw      = FlagWD;
        e_d.pcs        = PCSD;
        e_d.regw       = RegWD;
        e_d.memw       = MemWD;
        e_d.branch     = BranchD;
        e_d.memtoreg   = MemtoRegD;
        e_d.alusrc     = ALUSrcD;
        e_d.bedmem     = BEDmemD;
        e_d.bl         = BLD;
        e_d.alucontrol = ALUControlD;
        e_d.wa3        = WA3D;

        // Gate CLU enables with valid so a non-instruction can never write or redirect
        m_d            = CTRL_M_BUBBLE;
        m_d.valid      = e_q.valid;
        m_d.regwrite   = RegWriteE & e_q.valid;
        m_d.memwrite   = MemWriteE & e_q.valid;
        m_d.memtoreg   = e_q.memtoreg;
        m_d.bedmem     = e_q.bedmem;
        m_d.bl         = e_q.bl;
        m_d.pcsrc      = PCSrcE & e_q.valid;
        m_d.wa3        = e_q.wa3;

        w_d            = CTRL_W_BUBBLE;
        w_d.valid      = m_q.valid;
        w_d.regwrite   = m_q.regwrite;
        w_d.memtoreg   = m_q.memtoreg;
        w_d.bl         = m_q.bl;
        w_d.pcsrc      = m_q.pcsrc;
        w_d.wa3        = m_q.wa3;
    end

    pipe_reg #(.W($bits(ctrl_e_t)), .RST_VAL(CTRL_E_BUBBLE)) u_reg_e (
        .clk(clk), .rst(reset), .en(~StallE), .clr(FlushE), .d(e_d), .q(e_q)
    );

    pipe_reg #(.W($bits(ctrl_m_t)), .RST_VAL(CTRL_M_BUBBLE)) u_reg_m (
        .clk(clk), .rst(reset), .en(1'b1), .clr(e_hold), .d(m_d), .q(m_q)
    );

    pipe_reg #(.W($bits(ctrl_w_t)), .RST_VAL(CTRL_W_BUBBLE)) u_reg_w (
        .clk(clk), .rst(reset), .en(1'b1), .clr(1'b0), .d(w_d), .q(w_q)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt <= '0;
        end else if (w_q.valid) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    assign CondE       = e_q.cond;
    assign FlagWE      = e_q.flagw;
    assign ALUControlE = e_q.alucontrol;
    assign PCSE        = e_q.pcs;
    assign RegWE       = e_q.regw;
    assign MemWE       = e_q.memw;
    assign BranchE     = e_q.branch;
    assign MemtoRegE   = e_q.memtoreg;
    assign ALUSrcE     = e_q.alusrc;
    assign BEDmemE     = e_q.bedmem;
    assign BLE         = e_q.bl;
    assign ValidE      = e_q.valid;
    assign WA3E        = e_q.wa3;

    assign RegWriteM   = m_q.regwrite;
    assign MemWriteM   = m_q.memwrite;
    assign MemtoRegM   = m_q.memtoreg;
    assign BEDmemM     = m_q.bedmem;
    assign BLM         = m_q.bl;
    assign PCSrcM      = m_q.pcsrc;
    assign ValidM      = m_q.valid;
    assign WA3M        = m_q.wa3;

    assign RegWriteW   = w_q.regwrite;
    assign MemtoRegW   = w_q.memtoreg;
    assign BLW         = w_q.bl;
    assign PCSrcW      = w_q.pcsrc;
    assign ValidW      = w_q.valid;
    assign WA3W        = w_q.wa3;

    assign RetireCount = cnt;

endmodule

// File: tb/tb_ctrl_pipe.sv
// Scoreboard bench for ctrl_pipe: stimulus pushes expected stage contents,
// a negedge monitor pops and compares.
module tb_ctrl_pipe;

    localparam int unsigned CW = 4;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic StallE = 1'b0, FlushE = 1'b0, ValidD = 1'b0;
    logic [3:0] CondD = '0, ALUControlD = '0, WA3D = '0;
    logic [1:0] FlagWD = '0;
    logic PCSD = 1'b0, RegWD = 1'b0, MemWD = 1'b0, BranchD = 1'b0, MemtoRegD = 1'b0;
    logic ALUSrcD = 1'b0, BEDmemD = 1'b0, BLD = 1'b0;
    logic PCSrcE = 1'b0, RegWriteE = 1'b0, MemWriteE = 1'b0;

    logic [3:0] CondE, ALUControlE, WA3E, WA3M, WA3W;
    logic [1:0] FlagWE;
    logic PCSE, RegWE, MemWE, BranchE, MemtoRegE, ALUSrcE, BEDmemE, BLE, ValidE;
    logic RegWriteM, MemWriteM, MemtoRegM, BEDmemM, BLM, PCSrcM, ValidM;
    logic RegWriteW, MemtoRegW, BLW, PCSrcW, ValidW;
    logic [CW-1:0] RetireCount;

    ctrl_pipe #(.CNT_W(CW)) dut (
        .clk(clk), .reset(reset), .StallE(StallE), .FlushE(FlushE), .ValidD(ValidD),
        .CondD(CondD), .FlagWD(FlagWD), .PCSD(PCSD), .RegWD(RegWD), .MemWD(MemWD),
        .BranchD(BranchD), .MemtoRegD(MemtoRegD), .ALUSrcD(ALUSrcD), .BEDmemD(BEDmemD),
        .BLD(BLD), .ALUControlD(ALUControlD), .WA3D(WA3D),
        .PCSrcE(PCSrcE), .RegWriteE(RegWriteE), .MemWriteE(MemWriteE),
        .CondE(CondE), .FlagWE(FlagWE), .ALUControlE(ALUControlE), .PCSE(PCSE),
        .RegWE(RegWE), .MemWE(MemWE), .BranchE(BranchE), .MemtoRegE(MemtoRegE),
        .ALUSrcE(ALUSrcE), .BEDmemE(BEDmemE), .BLE(BLE), .ValidE(ValidE), .WA3E(WA3E),
        .RegWriteM(RegWriteM), .MemWriteM(MemWriteM), .MemtoRegM(MemtoRegM),
        .BEDmemM(BEDmemM), .BLM(BLM), .PCSrcM(PCSrcM), .ValidM(ValidM), .WA3M(WA3M),
        .RegWriteW(RegWriteW), .MemtoRegW(MemtoRegW), .BLW(BLW), .PCSrcW(PCSrcW),
        .ValidW(ValidW), .WA3W(WA3W), .RetireCount(RetireCount)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       v;
        logic [3:0] cond;
        logic [1:0] flagw;
        logic       pcs, regw, memw, br, m2r, alusrc, bed, bl;
        logic [3:0] aluc, wa3;
    } instr_t;

    typedef struct {
        logic [7:0]  d;
        int unsigned wedge;
    } wrec_t;

    logic [22:0]   eq[$];
    logic [10:0]   mq[$];
    wrec_t         wq[$];
    instr_t        e_m;
    int unsigned   stim_edge = 0;
    int unsigned   retired = 0;
    logic [CW-1:0] cnt_exp = '0;
    int unsigned   total = 0;
    int unsigned   bad = 0;

    function automatic logic [22:0] pack_e(input instr_t i);
        return {i.v, i.cond, i.flagw, i.pcs, i.regw, i.memw, i.br, i.m2r,
                i.alusrc, i.bed, i.bl, i.aluc, i.wa3};
    endfunction

    function automatic logic [22:0] dut_e();
        return {ValidE, CondE, FlagWE, PCSE, RegWE, MemWE, BranchE, MemtoRegE,
                ALUSrcE, BEDmemE, BLE, ALUControlE, WA3E};
    endfunction

    function automatic logic [10:0] dut_m();
        return {ValidM, RegWriteM, MemWriteM, MemtoRegM, BEDmemM, BLM, PCSrcM, WA3M};
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic qfail(input string nm);
        total++;
        bad++;
        $display("FAIL %s actual=empty required=entry at %0t", nm, $time);
    endtask

    task automatic clear_inputs();
        {CondD, FlagWD, PCSD, RegWD, MemWD, BranchD, MemtoRegD, ALUSrcD, BEDmemD, BLD,
         ALUControlD, WA3D, PCSrcE, RegWriteE, MemWriteE} = '0;
    endtask

    // Expected behaviour per clock: E flush/stall/load priority, M receives
    // the leaving E instruction (CLU-gated enables) or a bubble, W one edge later.
    task automatic step(input bit rnd, input logic v, input logic stall, input logic flush);
        logic [10:0] mexp;
        logic        adv;
        if (rnd) begin
            CondD = 4'($urandom); FlagWD = 2'($urandom); PCSD = 1'($urandom);
            RegWD = 1'($urandom); MemWD = 1'($urandom); BranchD = 1'($urandom);
            MemtoRegD = 1'($urandom); ALUSrcD = 1'($urandom); BEDmemD = 1'($urandom);
            BLD = 1'($urandom); ALUControlD = 4'($urandom); WA3D = 4'($urandom);
            PCSrcE = 1'($urandom); RegWriteE = 1'($urandom); MemWriteE = 1'($urandom);
        end
        ValidD = v;
        StallE = stall;
        FlushE = flush;
        @(posedge clk);
        stim_edge++;
        adv  = !(StallE && !FlushE);
        mexp = '0;
        if (adv) begin
            mexp = {e_m.v, RegWriteE & e_m.v, MemWriteE & e_m.v, e_m.m2r, e_m.bed, e_m.bl,
                    PCSrcE & e_m.v, e_m.wa3};
            if (e_m.v) begin
                wq.push_back('{d: {RegWriteE, e_m.m2r, e_m.bl, PCSrcE, e_m.wa3},
                               wedge: stim_edge + 1});
                retired++;
            end
        end
        mq.push_back(mexp);
        if (FlushE) begin
            e_m = '{default: '0};
        end else if (!StallE) begin
            e_m = '{v: ValidD, cond: CondD, flagw: FlagWD, pcs: PCSD, regw: RegWD,
                    memw: MemWD, br: BranchD, m2r: MemtoRegD, alusrc: ALUSrcD,
                    bed: BEDmemD, bl: BLD, aluc: ALUControlD, wa3: WA3D};
        end
        eq.push_back(pack_e(e_m));
        #1;
    endtask

    task automatic do_reset();
        #2 reset = 1'b1;
        #1;
        chk("reset_outputs", 64'({dut_e(), dut_m(), RegWriteW, MemtoRegW, BLW, PCSrcW,
                                  ValidW, WA3W}), 64'(0));
        chk("reset_count", 64'(RetireCount), 64'(0));
        @(negedge clk);
        @(negedge clk);
        eq.delete();
        mq.delete();
        wq.delete();
        e_m     = '{default: '0};
        cnt_exp = '0;
        retired = 0;
        chk("reset_count_held", 64'(RetireCount), 64'(0));
        @(posedge clk);
        #1 reset = 1'b0;
        eq.push_back('0);
        mq.push_back('0);
    endtask

    initial begin : monitor
        logic [22:0] ee;
        logic [10:0] me;
        wrec_t       wr;
        forever begin
            @(negedge clk);
            if (!reset) begin
                if (eq.size() == 0) qfail("e_queue");
                else begin
                    ee = eq.pop_front();
                    chk("e_stage", 64'(dut_e()), 64'(ee));
                end
                if (mq.size() == 0) qfail("m_queue");
                else begin
                    me = mq.pop_front();
                    chk("m_stage", 64'(dut_m()), 64'(me));
                end
                if (ValidW) begin
                    if (wq.size() == 0) qfail("w_queue");
                    else begin
                        wr = wq.pop_front();
                        chk("w_fields", 64'({RegWriteW, MemtoRegW, BLW, PCSrcW, WA3W}), 64'(wr.d));
                        chk("w_latency", 64'(stim_edge), 64'(wr.wedge));
                    end
                end else begin
                    chk("w_bubble_writes", 64'({RegWriteW, PCSrcW}), 64'(0));
                end
                chk("retire_count", 64'(RetireCount), 64'(cnt_exp));
                if (ValidW) cnt_exp = cnt_exp + CW'(1);
            end
        end
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "timeout");
    end

    initial begin : stimulus
        e_m = '{default: '0};
        @(posedge clk);
        #1;
        do_reset();

        // Straight-line register write: W fields appear two edges after E capture
        clear_inputs();
        RegWD = 1'b1; WA3D = 4'h5; RegWriteE = 1'b1;
        step(0, 1'b1, 1'b0, 1'b0);
        RegWD = 1'b0; WA3D = 4'h0;
        for (int i = 0; i < 4; i++) step(0, 1'b0, 1'b0, 1'b0);

        // Condition failed in CLU: still retires, no writes
        clear_inputs();
        RegWD = 1'b1; MemWD = 1'b1;
        step(0, 1'b1, 1'b0, 1'b0);
        RegWD = 1'b0; MemWD = 1'b0;
        for (int i = 0; i < 4; i++) step(0, 1'b0, 1'b0, 1'b0);

        // Two-cycle stall with changing D fields
        step(1, 1'b1, 1'b0, 1'b0);
        step(1, 1'b1, 1'b1, 1'b0);
        step(1, 1'b1, 1'b1, 1'b0);
        step(1, 1'b1, 1'b0, 1'b0);

        // Flush and stall together
        step(1, 1'b1, 1'b1, 1'b1);
        step(1, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) step(1, 1'b0, 1'b0, 1'b0);

        // Counter wrap: 17 retirements on a 4-bit counter
        do_reset();
        for (int i = 0; i < 17; i++) step(1, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) step(1, 1'b0, 1'b0, 1'b0);
        chk("wrap_count", 64'(RetireCount), 64'(1));

        // Random traffic with a reset in the middle
        for (int i = 0; i < 600; i++) begin
            if (i == 300) do_reset();
            step(1, 1'($urandom_range(0, 9) < 7), 1'($urandom_range(0, 9) < 2),
                 1'($urandom_range(0, 9) < 1));
        end
        for (int i = 0; i < 5; i++) step(1, 1'b0, 1'b0, 1'b0);
        chk("drain_w_queue", 64'(wq.size()), 64'(0));
        chk("final_count", 64'(RetireCount), 64'(CW'(retired)));

        @(negedge clk);
        #1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ctrl_pipe.md
# ctrl_pipe

Control-signal pipeline for the ARM pipelined processor: registers decoder outputs from Decode into Execute, then carries the condition-gated enables through Memory and Writeback. It sits between the decoder and the conditional-logic unit: its Execute-stage outputs drive the CLU inputs (CondE, ALUFlagsE path, FlagWE, PCSE, RegWE, MemWE, BranchE), and it consumes the CLU's gated PCSrc/RegWrite/MemWrite. It also implements bubble insertion for the hazard unit and a retired-instruction counter.

## Interface
- CNT_W, 32, width of retired-instruction counter
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high; clears every register
- StallE  in  1  hold Execute register
- FlushE  in  1  load bubble into Execute register
- ValidD  in  1  Decode holds a real instruction
- CondD  in  4  condition field
- FlagWD  in  2  flag-write enables
- PCSD, RegWD, MemWD, BranchD, MemtoRegD, ALUSrcD, BEDmemD, BLD  in  1 each  decoder controls
- ALUControlD  in  4  ALU operation
- WA3D  in  4  destination register
- PCSrcE, RegWriteE, MemWriteE  in  1 each  condition-gated enables from CLU
- CondE, FlagWE, ALUControlE  out  4/2/4  Execute fields
- PCSE, RegWE, MemWE, BranchE, MemtoRegE, ALUSrcE, BEDmemE, BLE, ValidE  out  1 each
- WA3E  out  4
- RegWriteM, MemWriteM, MemtoRegM, BEDmemM, BLM, PCSrcM, ValidM  out  1 each
- WA3M  out  4
- RegWriteW, MemtoRegW, BLW, PCSrcW, ValidW  out  1 each
- WA3W  out  4
- RetireCount  out  CNT_W  instructions retired since reset

## Operation
- Three register stages E, M, W; all outputs are register outputs (no combinational D->E path).
- Bubble = all fields 0 (CondE 4'h0, all enables 0, Valid 0). Reset value of every output is the bubble; RetireCount resets to 0.
- E register, per edge, priority: FlushE -> bubble; else StallE -> hold; else load D fields (ValidD included).
- M register: if StallE && !FlushE, load bubble (E not advancing); else load {RegWriteE, MemWriteE, MemtoRegE, BEDmemE, BLE, PCSrcE, WA3E, ValidE}. CLU-gated inputs are used, never raw RegWE/MemWE.
- W register: always loads M fields except MemWriteM/BEDmemM (not carried).
- RetireCount increments by 1 each edge where ValidW=1; wraps 2^CNT_W-1 -> 0.
- Bubbles never produce register/memory writes or PC redirects downstream.

## Timing
- Latency D->E 1 cycle, E->M 1, M->W 1; instruction leaves W one cycle after ValidW is seen (counted on that edge).
- FlushE && StallE together: bubble wins.
- Reset asserted mid-operation: all stages bubble immediately (async), counter 0; first valid instruction after release appears in E one edge after reset deasserts.
- Stall sequence of N cycles: E constant for N cycles, N bubbles enter M.

## Structure
- Package ctrl_pkg: packed structs ctrl_e_t, ctrl_m_t, ctrl_w_t; constants CTRL_E_BUBBLE, CTRL_M_BUBBLE, CTRL_W_BUBBLE.
- Sub-module pipe_reg (parameterized width): async active-high reset to a reset-value parameter, en, clr (clr over en). Instantiated three times; counter local.

## Test plan
- Reset mid-stream with valid instructions in E/M/W -> all outputs 0, RetireCount 0 while reset high.
- Straight-line: ValidD=1, RegWD=1, WA3D=4'h5, CLU returns RegWriteE=1 -> RegWriteW=1, WA3W=5 exactly 3 edges after D sampled; RetireCount +1 next edge.
- StallE for 2 cycles with ALUControlD changing -> ALUControlE held; M sees 2 bubbles (ValidM=0); count increments skip them.
- FlushE with StallE both high, ValidD=1 -> ValidE=0, all E enables 0 next edge.
- Condition fails: RegWE=1, MemWE=1 but CLU RegWriteE=0, MemWriteE=0 -> RegWriteM=0, MemWriteM=0, ValidM=1 (still retired).
- CNT_W=4, 17 back-to-back valid instructions -> RetireCount wraps 15 -> 0 and reads 1.
